// File: rtl/deskew_pkg.sv
// deskew_pkg
// Shared definitions for the multi-lane receive deskew block.
//   - deskew_state_e : lock/error FSM states (WAIT_AM, ALIGN, LOCKED)
//   - *_DEF          : default lane count, block width and buffer depth
//   - tagged_block_t : one buffered entry, {am, block}, at the default width
package deskew_pkg;

    localparam int LANE_N_DEF           = 4;
    localparam int BLOCK_W_DEF          = 66;
    localparam int MAX_SKEW_BLOCK_N_DEF = 27;

    typedef enum logic [1:0] {
        WAIT_AM = 2'd0,
        ALIGN   = 2'd1,
        LOCKED  = 2'd2
    } deskew_state_e;

    typedef struct packed {
        logic                   am;
        logic [BLOCK_W_DEF-1:0] block;
    } tagged_block_t;

endpackage

// File: rtl/deskew_buf_lane.sv
// deskew_buf_lane
// One lane's delay line: a DEPTH-entry shift buffer of {am tag, block}
// followed by a read mux selecting how many valid cycles of delay to apply.
// Ports:
//   clk      in   clock
//   shift_en in   advance the buffer (common block-valid)
//   am_i     in   marker tag of the incoming block
//   block_i  in   incoming block
//   rd_ptr   in   delay in valid cycles; 0 = live input, k = entry k-1
//   am_o     out  marker tag of the selected block
//   block_o  out  selected block
module deskew_buf_lane #(
    parameter int BLOCK_W = 66,
    parameter int DEPTH   = 27,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               shift_en,
    input  logic               am_i,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [CNT_W-1:0]   rd_ptr,
    output logic               am_o,
    output logic [BLOCK_W-1:0] block_o
);

    // Data storage only; contents are meaningless until filled, so no reset.
    logic [BLOCK_W:0] mem [DEPTH];
    logic [BLOCK_W:0] sel;

    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= {am_i, block_i};
            for (int k = 1; k < DEPTH; k++) begin
                mem[k] <= mem[k-1];
            end
        end
    end

    // Pointer 0 bypasses the buffer so the latest lane sees no added latency.
    always_comb begin
        sel = {am_i, block_i};
        for (int k = 0; k < DEPTH; k++) begin
            if (rd_ptr == CNT_W'(k + 1)) begin
                sel = mem[k];
            end
        end
    end

    assign am_o    = sel[BLOCK_W];
    assign block_o = sel[BLOCK_W-1:0];

endmodule

// File: rtl/deskew_multilane_rx.sv
// deskew_multilane_rx
// Multi-lane receive deskew. Measures inter-lane skew from the first
// alignment marker seen on each lane and delays every lane so all lanes
// line up on the latest one. Includes the lock/error FSM, valid gating,
// marker tagging and skew-overflow detection.
// Ports:
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   data_v_i       in   common block-valid; everything advances only when high
//   am_v_i         in   per-lane marker flag for data_i
//   am_lock_i      in   all lanes hold AM lock; low forces WAIT_AM
//   data_i         in   per-lane blocks, lane l at [l*BLOCK_W +: BLOCK_W]
//   data_v_o       out  deskewed output valid
//   data_o         out  deskewed blocks, zero when data_v_o low
//   am_v_o         out  per-lane marker tag of the deskewed block
//   deskew_lock_o  out  FSM in LOCKED
//   skew_err_o     out  one-cycle pulse on skew overflow or marker mismatch
//   skew_o         out  per-lane measured skew; 0 = latest lane
module deskew_multilane_rx
    import deskew_pkg::*;
#(
    parameter int LANE_N           = LANE_N_DEF,
    parameter int BLOCK_W          = BLOCK_W_DEF,
    parameter int MAX_SKEW_BLOCK_N = MAX_SKEW_BLOCK_N_DEF,
    parameter int CNT_W            = $clog2(MAX_SKEW_BLOCK_N + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_v_i,
    input  logic [LANE_N-1:0]         am_v_i,
    input  logic                      am_lock_i,
    input  logic [LANE_N*BLOCK_W-1:0] data_i,
    output logic                      data_v_o,
    output logic [LANE_N*BLOCK_W-1:0] data_o,
    output logic [LANE_N-1:0]         am_v_o,
    output logic                      deskew_lock_o,
    output logic                      skew_err_o,
    output logic [LANE_N*CNT_W-1:0]   skew_o
);

    deskew_state_e     state_q, state_d;
    logic [CNT_W-1:0]  skew_q [LANE_N];
    logic [CNT_W-1:0]  skew_d [LANE_N];
    logic [LANE_N-1:0] seen_q, seen_d;
    logic              err_q, err_d;
    logic              overflow;
    logic              dup;

    logic [LANE_N-1:0] am_buf;
    logic [BLOCK_W-1:0] blk_buf [LANE_N];

    // Output valid only while locked; data and tags are gated with it.
    assign data_v_o      = (state_q == LOCKED) && data_v_i;
    assign deskew_lock_o = (state_q == LOCKED);
    assign skew_err_o    = err_q;

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        deskew_buf_lane #(
            .BLOCK_W (BLOCK_W),
            .DEPTH   (MAX_SKEW_BLOCK_N),
            .CNT_W   (CNT_W)
        ) u_buf (
            .clk      (clk),
            .shift_en (data_v_i),
            .am_i     (am_v_i[l]),
            .block_i  (data_i[l*BLOCK_W +: BLOCK_W]),
            .rd_ptr   (skew_q[l]),
            .am_o     (am_buf[l]),
            .block_o  (blk_buf[l])
        );

        assign data_o[l*BLOCK_W +: BLOCK_W] = data_v_o ? blk_buf[l] : '0;
        assign am_v_o[l]                    = data_v_o & am_buf[l];
        assign skew_o[l*CNT_W +: CNT_W]     = skew_q[l];
    end

    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        err_d    = 1'b0;
        overflow = 1'b0;
        dup      = 1'b0;
        for (int l = 0; l < LANE_N; l++) begin
            skew_d[l] = skew_q[l];
        end

        case (state_q)
            WAIT_AM: begin
                for (int l = 0; l < LANE_N; l++) begin
                    skew_d[l] = '0;
                end
                seen_d = '0;
                if (data_v_i && (|am_v_i)) begin
                    seen_d  = am_v_i;
                    state_d = (&am_v_i) ? LOCKED : ALIGN;
                end
            end

            ALIGN: begin
                if (data_v_i) begin
                    // A lane marked twice, or a count that would pass the
                    // buffer depth, means the skew is not correctable.
                    dup = |(am_v_i & seen_q);
                    for (int l = 0; l < LANE_N; l++) begin
                        if (seen_q[l] && (skew_q[l] == CNT_W'(MAX_SKEW_BLOCK_N))) begin
                            overflow = 1'b1;
                        end
                    end
                    if (dup || overflow) begin
                        state_d = WAIT_AM;
                        err_d   = 1'b1;
                        seen_d  = '0;
                        for (int l = 0; l < LANE_N; l++) begin
                            skew_d[l] = '0;
                        end
                    end else begin
                        // Earlier-marked lanes accumulate delay; a lane marked
                        // now starts at 0 and is the latest so far.
                        for (int l = 0; l < LANE_N; l++) begin
                            if (seen_q[l]) begin
                                skew_d[l] = skew_q[l] + CNT_W'(1);
                            end
                        end
                        seen_d = seen_q | am_v_i;
                        if (&seen_d) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end

            LOCKED: begin
                // Real markers arrive on every lane at once after deskew;
                // a partial pattern means alignment has been lost.
                if (data_v_i && (am_v_o != '0) && (am_v_o != '1)) begin
                    state_d = WAIT_AM;
                    err_d   = 1'b1;
                    seen_d  = '0;
                    for (int l = 0; l < LANE_N; l++) begin
                        skew_d[l] = '0;
                    end
                end
            end

            default: begin
                state_d = WAIT_AM;
            end
        endcase

        // Losing upstream AM lock is not a deskew error: drop quietly.
        if (!am_lock_i) begin
            state_d = WAIT_AM;
            err_d   = 1'b0;
            seen_d  = '0;
            for (int l = 0; l < LANE_N; l++) begin
                skew_d[l] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_AM;
            seen_q  <= '0;
            err_q   <= 1'b0;
            for (int l = 0; l < LANE_N; l++) begin
                skew_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            for (int l = 0; l < LANE_N; l++) begin
                skew_q[l] <= skew_d[l];
            end
        end
    end

endmodule

// File: tb/tb_deskew_multilane_rx.sv
// tb_deskew_multilane_rx
// Directed sequence with random block payloads, checked every cycle against
// a reference model that tracks the valid-cycle index of each lane's first
// marker and reads expected outputs from a per-lane history of inputs.
module tb_deskew_multilane_rx;
    import deskew_pkg::*;

    localparam int LANE_N  = LANE_N_DEF;
    localparam int BLOCK_W = BLOCK_W_DEF;
    localparam int MAXS    = MAX_SKEW_BLOCK_N_DEF;
    localparam int CNT_W   = $clog2(MAXS + 1);
    localparam int DW      = LANE_N * BLOCK_W;
    localparam int SW      = LANE_N * CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              data_v_i;
    logic [LANE_N-1:0] am_v_i;
    logic              am_lock_i;
    logic [DW-1:0]     data_i;
    logic              data_v_o;
    logic [DW-1:0]     data_o;
    logic [LANE_N-1:0] am_v_o;
    logic              deskew_lock_o;
    logic              skew_err_o;
    logic [SW-1:0]     skew_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    tagged_block_t hist [LANE_N][$];
    int            first_at [LANE_N];
    int            m_skew [LANE_N];
    bit            m_locked;
    bit            m_err;
    int            n_done;

    always #5 clk = ~clk;

    deskew_multilane_rx dut (
        .clk           (clk),
        .reset         (reset),
        .data_v_i      (data_v_i),
        .am_v_i        (am_v_i),
        .am_lock_i     (am_lock_i),
        .data_i        (data_i),
        .data_v_o      (data_v_o),
        .data_o        (data_o),
        .am_v_o        (am_v_o),
        .deskew_lock_o (deskew_lock_o),
        .skew_err_o    (skew_err_o),
        .skew_o        (skew_o)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_locked = 1'b0;
        for (int l = 0; l < LANE_N; l++) begin
            first_at[l] = -1;
            m_skew[l]   = 0;
        end
    endtask

    task automatic model_lock(input int n);
        for (int l = 0; l < LANE_N; l++) begin
            m_skew[l] = n - first_at[l];
        end
        m_locked = 1'b1;
    endtask

    // Expected outputs for the current cycle from the model state.
    task automatic model_expect(input bit dv, input logic [LANE_N-1:0] am, input logic [DW-1:0] din,
                                output logic e_dv, output logic [DW-1:0] e_data,
                                output logic [LANE_N-1:0] e_am, output logic [SW-1:0] e_skew);
        tagged_block_t t;
        int v;
        e_dv   = m_locked && dv;
        e_data = '0;
        e_am   = '0;
        e_skew = '0;
        for (int l = 0; l < LANE_N; l++) begin
            if (m_locked) v = m_skew[l];
            else if (first_at[l] >= 0) v = (n_done - 1) - first_at[l];
            else v = 0;
            e_skew[l*CNT_W +: CNT_W] = CNT_W'(v);
            if (e_dv) begin
                if (m_skew[l] == 0) begin
                    t.am    = am[l];
                    t.block = din[l*BLOCK_W +: BLOCK_W];
                end else begin
                    t = hist[l][n_done - m_skew[l]];
                end
                e_data[l*BLOCK_W +: BLOCK_W] = t.block;
                e_am[l] = t.am;
            end
        end
    endtask

    task automatic model_update(input bit dv, input logic [LANE_N-1:0] am, input bit lk, input bit rs,
                                input logic [DW-1:0] din, input logic [LANE_N-1:0] e_am);
        tagged_block_t t;
        int  n;
        int  oldest;
        bit  any_seen;
        bit  dup;
        bit  all_seen;
        m_err = 1'b0;
        n = n_done;
        if (rs || !lk) begin
            model_clear();
        end else if (dv) begin
            any_seen = 1'b0;
            for (int l = 0; l < LANE_N; l++) if (first_at[l] >= 0) any_seen = 1'b1;
            if (m_locked) begin
                if (e_am != '0 && e_am != '1) begin
                    model_clear();
                    m_err = 1'b1;
                end
            end else if (!any_seen) begin
                if (am != '0) begin
                    for (int l = 0; l < LANE_N; l++) if (am[l]) first_at[l] = n;
                    if (&am) model_lock(n);
                end
            end else begin
                dup = 1'b0;
                oldest = n;
                for (int l = 0; l < LANE_N; l++) begin
                    if (first_at[l] >= 0) begin
                        if (am[l]) dup = 1'b1;
                        if (first_at[l] < oldest) oldest = first_at[l];
                    end
                end
                if (dup || (n - oldest) > MAXS) begin
                    model_clear();
                    m_err = 1'b1;
                end else begin
                    all_seen = 1'b1;
                    for (int l = 0; l < LANE_N; l++) begin
                        if (am[l]) first_at[l] = n;
                        if (first_at[l] < 0) all_seen = 1'b0;
                    end
                    if (all_seen) model_lock(n);
                end
            end
        end
        // The buffers shift on every valid cycle, reset or not.
        if (dv) begin
            for (int l = 0; l < LANE_N; l++) begin
                t.am    = am[l];
                t.block = din[l*BLOCK_W +: BLOCK_W];
                hist[l].push_back(t);
            end
            n_done++;
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic cycle(input bit dv, input logic [LANE_N-1:0] am, input bit lk, input bit rs);
        logic [95:0]       r;
        logic [DW-1:0]     din;
        logic              e_dv;
        logic [DW-1:0]     e_data;
        logic [LANE_N-1:0] e_am;
        logic [SW-1:0]     e_skew;
        for (int l = 0; l < LANE_N; l++) begin
            r = {$urandom(), $urandom(), $urandom()};
            din[l*BLOCK_W +: BLOCK_W] = r[BLOCK_W-1:0];
        end
        data_v_i  = dv;
        am_v_i    = am;
        am_lock_i = lk;
        reset     = rs;
        data_i    = din;
        #4;
        model_expect(dv, am, din, e_dv, e_data, e_am, e_skew);
        chk("data_v_o", DW'(data_v_o), DW'(e_dv));
        chk("data_o", data_o, e_data);
        chk("am_v_o", DW'(am_v_o), DW'(e_am));
        chk("deskew_lock_o", DW'(deskew_lock_o), DW'(m_locked));
        chk("skew_err_o", DW'(skew_err_o), DW'(m_err));
        chk("skew_o", DW'(skew_o), DW'(e_skew));
        @(posedge clk);
        model_update(dv, am, lk, rs, din, e_am);
        #1;
    endtask

    // Marks lane l at pattern index d[l], repeating with period P so that
    // the second round of markers should come out coincident after deskew.
    task automatic run_pattern(input int d [LANE_N], input bit gaps);
        int k = 0;
        int cyc = 0;
        int maxd = 0;
        int p;
        bit dv;
        logic [LANE_N-1:0] am;
        for (int l = 0; l < LANE_N; l++) if (d[l] > maxd) maxd = d[l];
        p = maxd + 8;
        while (k < 2 * p + 4) begin
            dv = !(gaps && (cyc % 3 == 2));
            am = '0;
            if (dv) for (int l = 0; l < LANE_N; l++) am[l] = ((k % p) == d[l]);
            cycle(dv, am, 1'b1, 1'b0);
            if (dv) k++;
            cyc++;
        end
    endtask

    initial begin
        int d [LANE_N];
        logic [SW-1:0] sk;
        reset     = 1'b1;
        data_v_i  = 1'b0;
        am_v_i    = '0;
        am_lock_i = 1'b1;
        data_i    = '0;
        model_clear();
        m_err  = 1'b0;
        n_done = 0;
        @(posedge clk);
        #1;

        // Reset values, then fill buffers with unmarked traffic
        chk("rst_lock", DW'(deskew_lock_o), DW'(1'b0));
        chk("rst_skew", DW'(skew_o), DW'(0));
        chk("rst_data_v", DW'(data_v_o), DW'(1'b0));
        for (int i = 0; i < 30; i++) cycle(1'b1, '0, 1'b1, 1'b0);

        // Zero skew
        cycle(1'b1, 4'hF, 1'b1, 1'b0);
        chk("zero_lock", DW'(deskew_lock_o), DW'(1'b1));
        chk("zero_skew", DW'(skew_o), DW'(0));
        for (int i = 0; i < 6; i++) cycle(1'b1, '0, 1'b1, 1'b0);

        // am_lock_i drop in LOCKED
        cycle(1'b1, '0, 1'b0, 1'b0);
        chk("amlock_lock", DW'(deskew_lock_o), DW'(1'b0));
        chk("amlock_err", DW'(skew_err_o), DW'(1'b0));
        chk("amlock_skew", DW'(skew_o), DW'(0));

        // Skew 12/7/3/0 on lanes 3/2/1/0, no gaps then with gaps
        d[0] = 12; d[1] = 9; d[2] = 5; d[3] = 0;
        sk = {5'd12, 5'd7, 5'd3, 5'd0};
        run_pattern(d, 1'b0);
        chk("skew_spec", DW'(skew_o), DW'(sk));
        chk("skew_locked", DW'(deskew_lock_o), DW'(1'b1));
        cycle(1'b1, '0, 1'b0, 1'b0);
        run_pattern(d, 1'b1);
        chk("gap_skew_spec", DW'(skew_o), DW'(sk));
        chk("gap_locked", DW'(deskew_lock_o), DW'(1'b1));
        cycle(1'b1, '0, 1'b0, 1'b0);

        // Overflow: lane 0 only, 28 silent valid cycles
        cycle(1'b1, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 27; i++) cycle(1'b1, '0, 1'b1, 1'b0);
        chk("ovf_not_yet", DW'(skew_err_o), DW'(1'b0));
        chk("ovf_count27", DW'(skew_o), DW'(20'd27));
        cycle(1'b1, '0, 1'b1, 1'b0);
        chk("ovf_pulse", DW'(skew_err_o), DW'(1'b1));
        chk("ovf_lock", DW'(deskew_lock_o), DW'(1'b0));
        chk("ovf_skew", DW'(skew_o), DW'(0));
        cycle(1'b1, '0, 1'b1, 1'b0);
        chk("ovf_pulse_end", DW'(skew_err_o), DW'(1'b0));

        // Marker mismatch after lock
        cycle(1'b1, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, 4'b0100, 1'b1, 1'b0);
        chk("mism_pulse", DW'(skew_err_o), DW'(1'b1));
        chk("mism_lock", DW'(deskew_lock_o), DW'(1'b0));
        cycle(1'b1, '0, 1'b1, 1'b0);

        // Second marker on an already-seen lane during ALIGN
        cycle(1'b1, 4'b0001, 1'b1, 1'b0);
        cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, 4'b0001, 1'b1, 1'b0);
        chk("dup_pulse", DW'(skew_err_o), DW'(1'b1));
        cycle(1'b1, '0, 1'b1, 1'b0);

        // Reset mid-ALIGN, relock, reset mid-LOCKED
        cycle(1'b1, 4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, '0, 1'b1, 1'b1);
        chk("rstA_skew", DW'(skew_o), DW'(0));
        chk("rstA_err", DW'(skew_err_o), DW'(1'b0));
        chk("rstA_lock", DW'(deskew_lock_o), DW'(1'b0));
        cycle(1'b1, 4'hF, 1'b1, 1'b0);
        chk("relock", DW'(deskew_lock_o), DW'(1'b1));
        cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, '0, 1'b1, 1'b1);
        chk("rstL_lock", DW'(deskew_lock_o), DW'(1'b0));
        chk("rstL_data_v", DW'(data_v_o), DW'(1'b0));
        chk("rstL_data", data_o, DW'(0));

        // Random skews
        for (int it = 0; it < 4; it++) begin
            for (int l = 0; l < LANE_N; l++) d[l] = $urandom_range(20, 0);
            run_pattern(d, it[0]);
            chk("rand_locked", DW'(deskew_lock_o), DW'(1'b1));
            cycle(1'b1, '0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
